// File: rtl/param_commit_pkg.sv
// +----------------------------------------------------------------------------+
// | param_commit_pkg : shared state encoding, slot map and default values for  |
// |                    the parameter commit controller.                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package param_commit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } commit_state_t;

  localparam int SLOT_PPS_IA      = 1;
  localparam int SLOT_PPS_II      = 2;
  localparam int SLOT_GAIN        = 3;
  localparam int SLOT_GAMMA_DYN   = 4;
  localparam int SLOT_GAMMA_STA   = 5;
  localparam int SLOT_GAIN_MN     = 6;
  localparam int SLOT_DELAY_CNT   = 7;
  localparam int SLOT_BDAMP_CHAIN = 13;
  localparam int SLOT_BDAMP_2     = 14;
  localparam int SLOT_BDAMP_1     = 15;

  // IEEE-754 single precision defaults (0.9, 80.0 and three small damping terms)
  localparam logic [31:0] DEF_F0P9   = 32'h3F66_6666;
  localparam logic [31:0] DEF_F80    = 32'h42A0_0000;
  localparam logic [31:0] DEF_BDAMP1 = 32'h3E71_4120;
  localparam logic [31:0] DEF_BDAMP2 = 32'h3D14_4674;
  localparam logic [31:0] DEF_BDAMPC = 32'h3C58_44D0;

endpackage

`default_nettype wire

// File: rtl/param_commit_ctrl_edge_sync_detect.sv
// +----------------------------------------------------------------------------+
// | edge_sync_detect : 2-FF synchroniser with registered rising-edge pulse.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module edge_sync_detect (
  input  logic clk,
  input  logic reset_global,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/param_commit_ctrl.sv
// +----------------------------------------------------------------------------+
// | param_commit_ctrl : shadow/active parameter bank committed atomically on   |
// |                     sim_clk boundaries. Optional PARAM_COMMIT_READBACK_EN. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module param_commit_ctrl
  import param_commit_pkg::*;
#(
  parameter int                      NSLOT      = 16,
  parameter logic [32*NSLOT-1:0]     RESET_VALS = {NSLOT{32'h0}}
) (
  input  logic                       clk,
  input  logic                       reset_global,
  input  logic                       reset_sim,
  input  logic [NSLOT-1:0]           trig,
  input  logic [15:0]                data_lo,
  input  logic [15:0]                data_hi,
  input  logic                       sim_clk,
  output logic [32*NSLOT-1:0]        params,
  output logic [NSLOT-1:0]           dirty,
  output logic                       commit_pulse,
  output logic                       boundary
`ifdef PARAM_COMMIT_READBACK_EN
  ,
  input  logic [$clog2(NSLOT)-1:0]   rd_sel,
  output logic [31:0]                rd_data
`endif
);

  commit_state_t r_state;
  commit_state_t w_state_next;

  logic [31:0]      r_shadow [NSLOT];
  logic [31:0]      r_active [NSLOT];
  logic [NSLOT-1:0] r_dirty;
  logic [NSLOT-1:0] w_commit_mask;
  logic [NSLOT-1:0] w_dirty_next;
  logic [31:0]      w_wr_val;
  logic             w_commit;
  logic             w_boundary;

  edge_sync_detect u_sim_clk_edge (
    .clk          (clk),
    .reset_global (reset_global),
    .i_async      (sim_clk),
    .o_rise       (w_boundary)
  );

  assign w_wr_val = {data_hi, data_lo};

  // A slot written in the commit cycle itself is excluded: its new value waits for the next boundary.
  assign w_commit_mask = (w_boundary | reset_sim) ? (r_dirty & ~trig) : '0;
  assign w_commit      = |w_commit_mask;
  assign w_dirty_next  = (r_dirty & ~w_commit_mask) | trig;

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_dirty <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_dirty <= w_dirty_next;
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (|trig) w_state_next = ST_ARMED;
      ST_ARMED:  if (w_commit) w_state_next = ST_COMMIT;
      ST_COMMIT: begin
        if (w_commit)           w_state_next = ST_COMMIT;
        else if (|w_dirty_next) w_state_next = ST_ARMED;
        else                    w_state_next = ST_IDLE;
      end
      default:   w_state_next = ST_IDLE;
    endcase
  end

  generate
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
          r_shadow[i] <= RESET_VALS[32*i +: 32];
          r_active[i] <= RESET_VALS[32*i +: 32];
        end else begin
          if (trig[i])          r_shadow[i] <= w_wr_val;
          if (w_commit_mask[i]) r_active[i] <= r_shadow[i];
        end
      end
      assign params[32*i +: 32] = r_active[i];
    end
  endgenerate

`ifdef PARAM_COMMIT_READBACK_EN
  logic [31:0] r_rd_data;

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) r_rd_data <= 32'h0;
    else              r_rd_data <= r_dirty[rd_sel] ? r_shadow[rd_sel] : r_active[rd_sel];
  end

  assign rd_data = r_rd_data;
`endif

  assign dirty        = r_dirty;
  assign commit_pulse = (r_state == ST_COMMIT);
  assign boundary     = w_boundary;

endmodule

`default_nettype wire

// File: doc/param_commit_ctrl.md
Name: param_commit_ctrl

Overview:
- Configuration sequencer for the spindle / neuron_pool / shadmehr_muscle datapath.
- Captures 32-bit parameters written by host trigger+wire pairs into shadow registers.
- Commits them atomically to active outputs only at a sim_clk step boundary, so no model sees a parameter change mid-step.
- Replaces per-parameter trigger-clocked registers with one synchronous block clocked by clk1.

Parameters:
- NSLOT, 16, number of parameter slots; slot i is written by trig[i].
- RESET_VALS, {NSLOT{32'h0}}, flattened reset values; slot i at bits [32*i +: 32].

Ports:
- clk  input  1  system clock (clk1); same domain as the okTriggerIn ep_clk.
- reset_global  input  1  asynchronous, active-high global reset.
- reset_sim  input  1  simulation reset (level, clk domain); forces transparent commit.
- trig  input  NSLOT  one-cycle trigger pulses, one per slot.
- data_lo  input  16  low half of the write value (ep01wire).
- data_hi  input  16  high half of the write value (ep02wire).
- sim_clk  input  1  slow simulation clock, asynchronous to clk; sampled only.
- params  output  32*NSLOT  active parameter values.
- dirty  output  NSLOT  slot has an uncommitted shadow value.
- commit_pulse  output  1  one clk cycle high on each commit that moved at least one slot.
- boundary  output  1  one clk cycle high per detected sim_clk rising edge.

Behaviour:
- Reset (reset_global high): shadow[i] = active[i] = RESET_VALS slot i; dirty = 0; commit_pulse = 0; boundary = 0; synchroniser flops = 0; FSM = IDLE.
- Write: on a cycle with trig[i] = 1, shadow[i] <= {data_hi, data_lo} and dirty[i] <= 1.
  - Several trig bits in the same cycle all load the same value.
  - A re-write before commit overwrites the shadow value; the last write wins.
- Boundary detect: sim_clk passes through a 2-FF synchroniser plus an edge register.
  - boundary is asserted 3 clk cycles after the sim_clk rising edge, for 1 cycle.
  - Falling edges are ignored.
- FSM:
  - IDLE: dirty == 0. Moves to ARMED on any write.
  - ARMED: dirty != 0. On a boundary cycle, moves to COMMIT.
  - COMMIT (1 cycle): active[i] <= shadow[i] for every dirty i; those dirty bits clear; commit_pulse = 1. Next state is ARMED if a write landed during COMMIT, else IDLE.
- Write on the boundary cycle:
  - The write goes to shadow and is NOT part of this commit.
  - dirty[i] stays or becomes 1; the slot commits at the next boundary.
  - If slot i was already dirty, the older value is lost.
- Write during the COMMIT cycle: same rule. The new value is kept in shadow, dirty[i] = 1.
- reset_sim high: the block is transparent.
  - Every cycle with dirty != 0 commits (active <= shadow, commit_pulse = 1), without waiting for a boundary.
  - A write with reset_sim high reaches params 2 cycles later (capture cycle, then commit cycle).
  - This guarantees parameters are valid when the sim starts.
  - reset_sim does not restore RESET_VALS.
- reset_global mid-operation: pending shadow writes are discarded and all slots return to RESET_VALS.
- params is registered and changes only in COMMIT or transparent-commit cycles; between commits it holds constant.
- No arithmetic; values are opaque 32-bit (IEEE float or integer, per slot).

Optional Feature:
- Macro: PARAM_COMMIT_READBACK_EN.
- Defined: adds ports rd_sel (input, $clog2(NSLOT)) and rd_data (output, 32).
  - rd_data is registered: shadow[rd_sel] if dirty[rd_sel], else active[rd_sel].
  - Latency is 1 clk cycle; reset value is 0.
  - Intended for okWireOut host readback.
- Undefined: these ports and that logic are absent; all other behaviour is identical.

Decomposition:
- Shared package param_commit_pkg holds:
  - FSM state encoding (IDLE, ARMED, COMMIT).
  - Slot index constants: SLOT_DELAY_CNT=7, SLOT_PPS_IA=1, SLOT_PPS_II=2, SLOT_GAIN=3, SLOT_GAMMA_DYN=4, SLOT_GAMMA_STA=5, SLOT_GAIN_MN=6, SLOT_BDAMP_CHAIN=13, SLOT_BDAMP_2=14, SLOT_BDAMP_1=15.
  - Default reset constants: 32'h3F66_6666, 32'h42A0_0000, 32'h3E71_4120, 32'h3D14_4674, 32'h3C58_44D0.
- One natural sub-module: edge_sync_detect (2-FF synchroniser plus rising-edge pulse), reused for sim_clk.

Test Plan:
- Reset: RESET_VALS slot4 = 32'h42A0_0000, reset_global pulse -> params slot4 = 42A00000, dirty = 0, commit_pulse never high.
- Deferred commit: trig[4] with data 0x4220/0x0000 -> dirty[4] = 1, params unchanged; sim_clk rise -> 3 cycles later boundary; next cycle params slot4 = 42200000, commit_pulse for 1 cycle, dirty = 0.
- Boundary collision: trig[1] with 0xAAAA_5555 on the exact boundary cycle, slot2 already dirty -> only slot2 commits; slot1 commits at the following sim_clk edge.
- Overwrite and broadcast:
  - Two writes to slot3 (5, then 9) before a boundary -> commit shows 9.
  - trig = 0x0006 with value 0x1234_5678 -> slots 1 and 2 both commit 12345678.
- Transparent mode: reset_sim = 1, trig[7] with 0x0000_00C8 -> params slot7 = 0xC8 within 2 cycles, with no sim_clk activity.
- Reset mid-operation: slot5 dirty, reset_global asserted -> slot5 = RESET_VALS, dirty = 0; the next boundary produces no commit_pulse.
